// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module : mem_arbiter_pkg
// Desc   : Shared state encoding, arbitration modes and index width.
// Rev    : 1.0  initial release
//==============================================================================
package mem_arbiter_pkg;

    localparam int c_max_ch = 8;
    localparam int c_idx_w  = $clog2(c_max_ch);

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_busy = 2'd1;
    localparam state_t c_st_resp = 2'd2;

    localparam logic c_mode_fixed = 1'b0;
    localparam logic c_mode_rr    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
`default_nettype none
//==============================================================================
// Module : arb_pick
// Desc   : Combinational request picker, fixed or rotating priority.
// Rev    : 1.0  initial release
//==============================================================================
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0]    req,
    input  logic [c_idx_w-1:0] ptr,
    input  logic               mode,
    output logic [N_CH-1:0]    gnt,
    output logic [c_idx_w-1:0] idx
);

    int              w_start;
    logic [N_CH-1:0] w_mask;
    logic [N_CH-1:0] w_src;

    // Requests at or above the start point take precedence; otherwise wrap to the bottom.
    always_comb begin
        w_start = (mode == c_mode_rr) ? int'(ptr) : 0;
        w_mask  = '0;
        for (int j = 0; j < N_CH; j++) begin
            w_mask[j] = req[j] && (j >= w_start);
        end
        w_src = (|w_mask) ? w_mask : req;
        gnt   = '0;
        idx   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (w_src[j]) begin
                gnt = N_CH'(1) << j;
                idx = c_idx_w'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module : mem_arbiter
// Desc   : N-channel arbiter onto a single memory port with timeout abort.
// Rev    : 1.0  initial release
//==============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_cs,
    input  logic [N_CH-1:0]        ch_we,
    input  logic [N_CH*ADDR_W-1:0] ch_addr,
    input  logic [N_CH*DATA_W-1:0] ch_din,
    output logic [DATA_W-1:0]      ch_dout,
    output logic [N_CH-1:0]        ch_ack,
    output logic [N_CH-1:0]        ch_err,
    output logic [N_CH-1:0]        gnt_o,
    output logic                   mem_cs_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_data_o,
    input  logic [DATA_W-1:0]      mem_data_i,
    input  logic                   mem_ack_i
);

    localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_tc = c_cnt_w'(TIMEOUT - 1);
    localparam logic c_mode = (RR_MODE != 0) ? c_mode_rr : c_mode_fixed;

    state_t               r_state;
    state_t               w_next;
    logic [c_idx_w-1:0]   r_ptr;
    logic [N_CH-1:0]      r_gnt;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_din;
    logic [DATA_W-1:0]    r_dout;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [N_CH-1:0]      w_pick_gnt;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic [c_idx_w-1:0]   w_ptr_next;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_din;
    logic                 w_timeout;

    arb_pick #(.N_CH(N_CH)) u_pick (
        .req  (ch_cs),
        .ptr  (r_ptr),
        .mode (c_mode),
        .gnt  (w_pick_gnt),
        .idx  (w_pick_idx)
    );

    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_pick_gnt[i]) begin
                w_sel_we   = ch_we[i];
                w_sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
                w_sel_din  = ch_din[i*DATA_W +: DATA_W];
            end
        end
        w_ptr_next = (w_pick_idx == c_idx_w'(N_CH - 1)) ? '0 : w_pick_idx + c_idx_w'(1);
        w_timeout  = (TIMEOUT != 0) && (r_cnt == c_tc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (|ch_cs) w_next = c_st_busy;
            c_st_busy: if (mem_ack_i || w_timeout) w_next = c_st_resp;
            c_st_resp: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // Request capture, timeout counting and response data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            r_dout <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|ch_cs) begin
                        r_gnt  <= w_pick_gnt;
                        r_ptr  <= w_ptr_next;
                        r_we   <= w_sel_we;
                        r_addr <= w_sel_addr;
                        r_din  <= w_sel_din;
                        r_err  <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                c_st_busy: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (mem_ack_i) begin
                        r_dout <= r_we ? '0 : mem_data_i;
                    end else if (w_timeout) begin
                        r_dout <= '0;
                        r_err  <= 1'b1;
                    end
                end
                c_st_resp: r_gnt <= '0;
                default:   r_gnt <= '0;
            endcase
        end
    end

    always_comb begin
        mem_cs_o   = (r_state == c_st_busy);
        mem_we_o   = mem_cs_o && r_we;
        mem_addr_o = mem_cs_o ? r_addr : '0;
        mem_data_o = mem_cs_o ? r_din : '0;
        ch_ack     = (r_state == c_st_resp) ? r_gnt : '0;
        ch_err     = ((r_state == c_st_resp) && r_err) ? r_gnt : '0;
        gnt_o      = r_gnt;
        ch_dout    = r_dout;
    end

endmodule
`default_nettype wire
